basic_gemm_cim: RTL and testbench

// - 1024x8 SRAM macro with a compute-in-memory (CIM) GeMM mode; the storage element behind the attention Score stage.
// - Memory mode: synchronous byte read/write on a single port.
// - CIM mode: 4 row groups x 8 columns multiply-accumulate against 4 inputs.

---
 rtl/basic_gemm_cim.sv | 103 ++++++++++
 tb/tb_basic_gemm_cim.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/basic_gemm_cim.sv
// 1024x8 single-port SRAM macro with a compute-in-memory GeMM mode:
// 4 row groups x 8 columns MAC against 4 unsigned inputs, each sum quantised by MSB truncation.
module basic_gemm_cim #(
  parameter int CIM_INPUT_PRECISION = 4,
  parameter int ADC_PRECISION       = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cs,
  input  logic                           web,
  input  logic                           cimeb,
  input  logic [9:0]                     a,
  input  logic [7:0]                     d,
  output logic [7:0]                     q,
  input  logic [CIM_INPUT_PRECISION-1:0] cim_in0,
  input  logic [CIM_INPUT_PRECISION-1:0] cim_in1,
  input  logic [CIM_INPUT_PRECISION-1:0] cim_in2,
  input  logic [CIM_INPUT_PRECISION-1:0] cim_in3,
  output logic [ADC_PRECISION-1:0]       cim_out0,
  output logic [ADC_PRECISION-1:0]       cim_out1,
  output logic [ADC_PRECISION-1:0]       cim_out2,
  output logic [ADC_PRECISION-1:0]       cim_out3,
  output logic [ADC_PRECISION-1:0]       cim_out4,
  output logic [ADC_PRECISION-1:0]       cim_out5,
  output logic [ADC_PRECISION-1:0]       cim_out6,
  output logic [ADC_PRECISION-1:0]       cim_out7
);

  localparam int ACC_W = CIM_INPUT_PRECISION + 8 + 2;

  logic [7:0]                     mem [1024];
  logic [7:0]                     q_reg;
  logic [CIM_INPUT_PRECISION-1:0] cim_in [4];
  logic [ACC_W-1:0]               sum [8];
  logic [ADC_PRECISION-1:0]       cim_out_reg [8];

  logic do_cim;
  logic do_write;
  logic do_read;

  assign cim_in[0] = cim_in0;
  assign cim_in[1] = cim_in1;
  assign cim_in[2] = cim_in2;
  assign cim_in[3] = cim_in3;

  // CIM has priority over both memory operations; cs gates everything.
  assign do_cim   = cs && !cimeb;
  assign do_write = cs && cimeb && !web;
  assign do_read  = cs && cimeb && web;

  // Storage is deliberately left out of reset so contents survive a rst pulse.
  always_ff @(posedge clk) begin
    if (do_write && !rst) begin
      mem[a] <= d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= '0;
    end else if (do_read) begin
      q_reg <= mem[a];
    end
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_col
      logic [9:0]       addr;
      logic [ACC_W-1:0] acc;

      // Column gi reads one cell per row group: {group, a[7:5], column, a[1:0]}.
      always_comb begin
        acc  = '0;
        addr = '0;
        for (int i = 0; i < 4; i++) begin
          addr = {2'(i), a[7:5], 3'(gi), a[1:0]};
          acc  = acc + ACC_W'(cim_in[i]) * ACC_W'(mem[addr]);
        end
      end

      assign sum[gi] = acc;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cim_out_reg[gi] <= '0;
        end else if (do_cim) begin
          cim_out_reg[gi] <= sum[gi][ACC_W-1 -: ADC_PRECISION];
        end
      end
    end
  endgenerate

  assign q        = q_reg;
  assign cim_out0 = cim_out_reg[0];
  assign cim_out1 = cim_out_reg[1];
  assign cim_out2 = cim_out_reg[2];
  assign cim_out3 = cim_out_reg[3];
  assign cim_out4 = cim_out_reg[4];
  assign cim_out5 = cim_out_reg[5];
  assign cim_out6 = cim_out_reg[6];
  assign cim_out7 = cim_out_reg[7];

endmodule

// File: tb/tb_basic_gemm_cim.sv
// Directed self-checking bench for basic_gemm_cim: reset, write/read sweep, CIM sweeps,
// address map, priority and chip-select behaviour.
module tb_basic_gemm_cim;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs;
  logic       web;
  logic       cimeb;
  logic [9:0] a;
  logic [7:0] d;
  logic [7:0] q;
  logic [3:0] cin [4];
  logic [5:0] cout [8];

  logic [7:0] mem_m [1024];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  basic_gemm_cim #(.CIM_INPUT_PRECISION(4), .ADC_PRECISION(6)) dut (
    .clk(clk), .rst(rst), .cs(cs), .web(web), .cimeb(cimeb),
    .a(a), .d(d), .q(q),
    .cim_in0(cin[0]), .cim_in1(cin[1]), .cim_in2(cin[2]), .cim_in3(cin[3]),
    .cim_out0(cout[0]), .cim_out1(cout[1]), .cim_out2(cout[2]), .cim_out3(cout[3]),
    .cim_out4(cout[4]), .cim_out5(cout[5]), .cim_out6(cout[6]), .cim_out7(cout[7])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mem(input logic [9:0] addr, input logic [7:0] data);
    cs = 1'b1; cimeb = 1'b1; web = 1'b0; a = addr; d = data;
    step();
    mem_m[addr] = data;
  endtask

  // Reference: ideal MAC over the four row groups, truncated to bits [13:8].
  function automatic logic [5:0] cim_ref(input int k, input logic [9:0] addr);
    int s;
    logic [9:0] ra;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      ra = {i[1:0], addr[7:5], k[2:0], addr[1:0]};
      s  = s + int'(cin[i]) * int'(mem_m[ra]);
    end
    return 6'((s >> 8) & 63);
  endfunction

  initial begin
    rst = 1'b1; cs = 1'b0; web = 1'b1; cimeb = 1'b1; a = '0; d = '0;
    for (int i = 0; i < 4; i++) cin[i] = '0;

    // Reset state
    step(); step();
    check("reset_q", q, 0);
    for (int k = 0; k < 8; k++) check($sformatf("reset_cim_out%0d", k), cout[k], 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Write/read sweep with random data
    for (int i = 0; i < 1024; i++) write_mem(10'(i), 8'($urandom_range(0, 255)));
    web = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      a = 10'(i);
      step();
      check($sformatf("read_%0d", i), q, mem_m[i]);
    end

    // CIM random sweep over all addresses
    cimeb = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      a = 10'(i);
      for (int g = 0; g < 4; g++) cin[g] = 4'($urandom_range(0, 15));
      #1;
      step();
      for (int k = 0; k < 8; k++) check($sformatf("cim_rand_a%0d_col%0d", i, k), cout[k], cim_ref(k, 10'(i)));
    end

    // CIM max: 4*15*255 = 15300 -> bits [13:8] = 59
    for (int i = 0; i < 1024; i++) write_mem(10'(i), 8'hFF);
    cimeb = 1'b0; web = 1'b1;
    for (int g = 0; g < 4; g++) cin[g] = 4'hF;
    a = 10'h2A7;
    step();
    for (int k = 0; k < 8; k++) check($sformatf("cim_max_col%0d", k), cout[k], 59);

    // CIM address map: only column 0 of each group at a[7:5]=2, a[1:0]=1 holds 0x80
    for (int i = 0; i < 1024; i++) write_mem(10'(i), 8'h00);
    for (int g = 0; g < 4; g++) write_mem({g[1:0], 3'd2, 3'd0, 2'd1}, 8'h80);
    cimeb = 1'b1; web = 1'b1; a = 10'h041;
    step();
    check("map_pre_read_q", q, 8'h80);
    cimeb = 1'b0;
    for (int g = 0; g < 4; g++) cin[g] = 4'd8;
    a = 10'b11_010_111_01;
    step();
    check("map_cim_out0", cout[0], 16);
    for (int k = 1; k < 8; k++) check($sformatf("map_cim_out%0d", k), cout[k], 0);
    check("map_q_hold", q, 8'h80);

    // Priority: CIM wins over write
    cimeb = 1'b0; web = 1'b0; a = 10'h041; d = 8'h55;
    step();
    check("prio_q_hold", q, 8'h80);
    check("prio_cim_out0", cout[0], 16);
    cimeb = 1'b1; web = 1'b1;
    step();
    check("prio_mem_unchanged", q, 8'h80);

    // cs=0: no write, outputs hold
    cs = 1'b0; cimeb = 1'b1; web = 1'b0; d = 8'h11;
    step();
    cimeb = 1'b0;
    for (int g = 0; g < 4; g++) cin[g] = 4'd0;
    step();
    check("cs0_q_hold", q, 8'h80);
    check("cs0_cim_out0_hold", cout[0], 16);
    cs = 1'b1; cimeb = 1'b1; web = 1'b1;
    step();
    check("cs0_no_write", q, 8'h80);

    // Asynchronous reset mid-operation, memory preserved
    cimeb = 1'b0;
    for (int g = 0; g < 4; g++) cin[g] = 4'd8;
    step();
    check("pre_rst_cim_out0", cout[0], 16);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_q", q, 0);
    for (int k = 0; k < 8; k++) check($sformatf("async_rst_cim_out%0d", k), cout[k], 0);
    rst = 1'b0;
    cimeb = 1'b1; web = 1'b1; a = 10'h041;
    step();
    check("post_rst_read_041", q, 8'h80);
    a = 10'h141;
    step();
    check("post_rst_read_141", q, 8'h80);
    a = 10'h000;
    step();
    check("post_rst_read_000", q, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
